// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU multiplier front end: rounding modes,
// arbiter FSM encoding, the default quiet NaN and the response flag layout.
package fpu_pkg;

   typedef enum logic [1:0] {
      to_Near = 2'b00,
      to_Zero = 2'b01,
      to_Pinf = 2'b10,
      to_Ninf = 2'b11
   } rmode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      BUSY  = 2'b10,
      RESP  = 2'b11
   } state_e;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Response flags are {timeout, invalid, overflow, underflow, inexact}.
   localparam int FLAGS_W       = 5;
   localparam int FLG_INEXACT   = 0;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_INVALID   = 3;
   localparam int FLG_TIMEOUT   = 4;

   // An aborted operation reports an invalid result plus the timeout marker.
   function automatic logic [FLAGS_W-1:0] timeout_flags();
      logic [FLAGS_W-1:0] f;
      f              = '0;
      f[FLG_TIMEOUT] = 1'b1;
      f[FLG_INVALID] = 1'b1;
      return f;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins, and on a tie
// the requester that was not served last wins.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_served,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_served ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one external FP multiplier core between two requesters, one
// operation in flight at a time, with a bounded wait for the core result.
module fpu_mul_arbiter
   import fpu_pkg::*;
#(
   parameter int LAT     = 3,
   parameter int TIMEOUT = 16
) (
   input  logic         CLK,
   input  logic         RST,

   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [31:0]  req0_a,
   input  logic [31:0]  req0_b,
   input  logic [1:0]   req0_rmode,

   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [31:0]  req1_a,
   input  logic [31:0]  req1_b,
   input  logic [1:0]   req1_rmode,

   output logic         core_start,
   output logic [31:0]  core_a,
   output logic [31:0]  core_b,
   output logic [1:0]   core_rmode,
   input  logic         core_done,
   input  logic [31:0]  core_z,
   input  logic [3:0]   core_flags,

   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [31:0]  rsp0_z,
   output logic [4:0]   rsp0_flags,

   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [31:0]  rsp1_z,
   output logic [4:0]   rsp1_flags
);

   // A TIMEOUT that does not exceed LAT is widened so a healthy core never times out.
   localparam int                TMO   = (TIMEOUT > LAT) ? TIMEOUT : LAT + 1;
   localparam int                CNT_W = $clog2(TMO + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TMO);

   state_e                 state_q, state_d;
   logic                   last_served_q, last_served_d;
   logic                   owner_q, owner_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   core_start_q, core_start_d;
   logic [31:0]            core_a_q, core_a_d;
   logic [31:0]            core_b_q, core_b_d;
   logic [1:0]             core_rmode_q, core_rmode_d;
   logic [1:0]             rsp_valid_q, rsp_valid_d;
   logic [31:0]            res_z_q, res_z_d;
   logic [FLAGS_W-1:0]     res_flags_q, res_flags_d;

   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic [1:0]             rsp_ready;
   logic [1:0]             grant;
   logic                   accept;
   logic                   sel;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};

   rr_arb2 u_arb (
      .valid       (req_valid),
      .last_served (last_served_q),
      .grant       (grant)
   );

   // Ready is held low during reset so nothing can be accepted into a clearing FSM.
   assign req_ready = (RST && (state_q == IDLE)) ? grant : 2'b00;
   assign accept    = |(req_valid & req_ready);
   assign sel       = grant[1];

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      owner_d       = owner_q;
      cnt_d         = cnt_q;
      core_start_d  = 1'b0;
      core_a_d      = core_a_q;
      core_b_d      = core_b_q;
      core_rmode_d  = core_rmode_q;
      rsp_valid_d   = rsp_valid_q;
      res_z_d       = res_z_q;
      res_flags_d   = res_flags_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d      = sel;
               core_a_d     = sel ? req1_a     : req0_a;
               core_b_d     = sel ? req1_b     : req0_b;
               core_rmode_d = sel ? req1_rmode : req0_rmode;
               core_start_d = 1'b1;
               state_d      = ISSUE;
            end
         end

         ISSUE: begin
            cnt_d   = '0;
            state_d = BUSY;
         end

         BUSY: begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            // A result arriving on the deadline cycle still beats the abort.
            if (core_done) begin
               res_z_d              = core_z;
               res_flags_d          = {1'b0, core_flags};
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = RESP;
            end else if (cnt_q == CNT_MAX) begin
               res_z_d              = QNAN;
               res_flags_d          = timeout_flags();
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = RESP;
            end
         end

         RESP: begin
            if (rsp_ready[owner_q]) begin
               rsp_valid_d   = 2'b00;
               res_z_d       = '0;
               res_flags_d   = '0;
               last_served_d = owner_q;
               state_d       = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         owner_q       <= 1'b0;
         cnt_q         <= '0;
         core_start_q  <= 1'b0;
         core_a_q      <= '0;
         core_b_q      <= '0;
         core_rmode_q  <= '0;
         rsp_valid_q   <= 2'b00;
         res_z_q       <= '0;
         res_flags_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         core_start_q  <= core_start_d;
         core_a_q      <= core_a_d;
         core_b_q      <= core_b_d;
         core_rmode_q  <= core_rmode_d;
         rsp_valid_q   <= rsp_valid_d;
         res_z_q       <= res_z_d;
         res_flags_q   <= res_flags_d;
      end
   end

   assign req0_ready = req_ready[0];
   assign req1_ready = req_ready[1];

   assign core_start = core_start_q;
   assign core_a     = core_a_q;
   assign core_b     = core_b_q;
   assign core_rmode = core_rmode_q;

   assign rsp0_valid = rsp_valid_q[0];
   assign rsp1_valid = rsp_valid_q[1];
   assign rsp0_z     = rsp_valid_q[0] ? res_z_q     : '0;
   assign rsp1_z     = rsp_valid_q[1] ? res_z_q     : '0;
   assign rsp0_flags = rsp_valid_q[0] ? res_flags_q : '0;
   assign rsp1_flags = rsp_valid_q[1] ? res_flags_q : '0;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: the bench plays the multiplier core and
// both requesters, with hand-computed expected results per transaction.
module tb_fpu_mul_arbiter;

   localparam int LAT     = 3;
   localparam int TIMEOUT = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [1:0]  req0_rmode = '0, req1_rmode = '0;
   logic        core_start;
   logic [31:0] core_a, core_b;
   logic [1:0]  core_rmode;
   logic        core_done = 1'b0;
   logic [31:0] core_z = '0;
   logic [3:0]  core_flags = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_z, rsp1_z;
   logic [4:0]  rsp0_flags, rsp1_flags;

   int n_checks = 0;
   int n_errs   = 0;

   logic [1:0]  rv, rr;
   logic [31:0] rz [2];
   logic [4:0]  rf [2];

   assign rv    = {rsp1_valid, rsp0_valid};
   assign rr    = {req1_ready, req0_ready};
   assign rz[0] = rsp0_z;
   assign rz[1] = rsp1_z;
   assign rf[0] = rsp0_flags;
   assign rf[1] = rsp1_flags;

   always #5 CLK = ~CLK;

   fpu_mul_arbiter #(.LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_rmode (req0_rmode),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_rmode (req1_rmode),
      .core_start (core_start),
      .core_a     (core_a),
      .core_b     (core_b),
      .core_rmode (core_rmode),
      .core_done  (core_done),
      .core_z     (core_z),
      .core_flags (core_flags),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_z     (rsp0_z),
      .rsp0_flags (rsp0_flags),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_z     (rsp1_z),
      .rsp1_flags (rsp1_flags)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input int who, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] rm);
      if (who == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_rmode = rm;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_rmode = rm;
      end
   endtask

   task automatic set_rsp_ready(input int who, input logic v);
      if (who == 0) rsp0_ready = v;
      else          rsp1_ready = v;
   endtask

   // One full transaction; give_done=0 leaves the core silent to force a timeout.
   task automatic run_op(input int who, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, input logic give_done,
                         input logic [31:0] cz, input logic [3:0] cf, input int hold);
      logic [31:0] exp_z;
      logic [4:0]  exp_f;
      int          n;
      exp_z = give_done ? cz : 32'h7FC0_0000;
      exp_f = give_done ? {1'b0, cf} : 5'b11000;

      set_req(who, 1'b1, a, b, rm);
      #1;
      check_eq("ready_own", 32'(rr[who]), 32'd1);
      check_eq("ready_other", 32'(rr[1-who]), 32'd0);
      step();
      set_req(who, 1'b0, 32'h0, 32'h0, 2'b00);
      check_eq("core_start_hi", 32'(core_start), 32'd1);
      check_eq("core_a", core_a, a);
      check_eq("core_b", core_b, b);
      check_eq("core_rmode", 32'(core_rmode), 32'(rm));

      n = 0;
      do begin
         step();
         n++;
         core_done  = give_done && (n == LAT);
         core_z     = cz;
         core_flags = cf;
      end while (!rv[who] && n < 40);
      core_done = 1'b0;

      check_eq("rsp_latency", n, give_done ? LAT + 1 : TIMEOUT + 2);
      check_eq("rsp_valid", 32'(rv[who]), 32'd1);
      check_eq("rsp_valid_other", 32'(rv[1-who]), 32'd0);
      check_eq("rsp_z", rz[who], exp_z);
      check_eq("rsp_flags", 32'(rf[who]), 32'(exp_f));
      check_eq("rsp_z_other", rz[1-who], 32'h0);
      check_eq("core_start_lo", 32'(core_start), 32'd0);

      for (int h = 0; h < hold; h++) begin
         step();
         check_eq("hold_valid", 32'(rv[who]), 32'd1);
         check_eq("hold_z", rz[who], exp_z);
         check_eq("hold_flags", 32'(rf[who]), 32'(exp_f));
         check_eq("hold_ready", 32'(rr), 32'd0);
         check_eq("hold_start", 32'(core_start), 32'd0);
      end

      set_rsp_ready(who, 1'b1);
      step();
      set_rsp_ready(who, 1'b0);
      check_eq("post_valid", 32'(rv[who]), 32'd0);
      check_eq("post_z", rz[who], 32'h0);
      check_eq("post_flags", 32'(rf[who]), 32'd0);
      $display("TXN req%0d a=%h b=%h rm=%0d -> z=%h flags=%b cycles=%0d", who, a, b, rm, exp_z, exp_f, n);
   endtask

   initial begin
      // Reset state, with a request pending to confirm ready stays low.
      RST = 1'b0;
      set_req(0, 1'b1, 32'h1111_1111, 32'h2222_2222, 2'b11);
      step();
      step();
      check_eq("rst_ready0", 32'(req0_ready), 32'd0);
      check_eq("rst_core_start", 32'(core_start), 32'd0);
      check_eq("rst_core_a", core_a, 32'h0);
      check_eq("rst_core_rmode", 32'(core_rmode), 32'd0);
      check_eq("rst_rsp_valid", 32'(rv), 32'd0);
      check_eq("rst_rsp0_z", rsp0_z, 32'h0);
      set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
      RST = 1'b1;

      // 3.0 * 2.0 = 6.0, round to nearest.
      run_op(0, 32'h4040_0000, 32'h4000_0000, 2'b00, 1'b1, 32'h40C0_0000, 4'b0000, 0);

      // Fresh reset then a tie: req0 first, then req1 although req0 is pending again.
      RST = 1'b0;
      step();
      RST = 1'b1;
      set_req(1, 1'b1, 32'h3F80_0000, 32'h4080_0000, 2'b01);
      run_op(0, 32'h3FC0_0000, 32'h3FC0_0000, 2'b01, 1'b1, 32'h4010_0000, 4'b0101, 0);
      set_req(0, 1'b1, 32'h4100_0000, 32'h4100_0000, 2'b10);
      run_op(1, 32'h3F80_0000, 32'h4080_0000, 2'b01, 1'b1, 32'h4080_0000, 4'b0001, 5);
      set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);

      // Silent core on requester 1: timeout with quiet NaN.
      run_op(1, 32'h7F80_0000, 32'h0000_0000, 2'b11, 1'b0, 32'h1234_5678, 4'b1111, 1);

      // Reset while BUSY, then a stray core_done afterwards.
      set_req(0, 1'b1, 32'h4040_0000, 32'h4040_0000, 2'b00);
      step();
      set_req(0, 1'b0, 32'h0, 32'h0, 2'b00);
      step();
      step();
      RST = 1'b0;
      step();
      RST = 1'b1;
      check_eq("midrst_core_start", 32'(core_start), 32'd0);
      check_eq("midrst_core_a", core_a, 32'h0);
      check_eq("midrst_rsp_valid", 32'(rv), 32'd0);
      core_done  = 1'b1;
      core_z     = 32'h4110_0000;
      core_flags = 4'b0000;
      step();
      core_done = 1'b0;
      check_eq("stray_rsp_valid", 32'(rv), 32'd0);
      check_eq("stray_rsp0_z", rsp0_z, 32'h0);
      step();
      check_eq("stray_rsp_valid2", 32'(rv), 32'd0);
      run_op(0, 32'h4040_0000, 32'h4040_0000, 2'b00, 1'b1, 32'h4110_0000, 4'b0000, 0);

      // core_done while IDLE must change nothing.
      core_done  = 1'b1;
      core_z     = 32'hDEAD_BEEF;
      core_flags = 4'b1111;
      step();
      core_done = 1'b0;
      check_eq("idle_done_rsp_valid", 32'(rv), 32'd0);
      check_eq("idle_done_rsp0_z", rsp0_z, 32'h0);
      check_eq("idle_done_rsp1_flags", 32'(rsp1_flags), 32'd0);
      check_eq("idle_done_core_start", 32'(core_start), 32'd0);
      check_eq("idle_done_core_a", core_a, 32'h4040_0000);
      step();
      check_eq("idle_done_rsp_valid2", 32'(rv), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
